wb_stage: RTL and testbench

Write-back stage sitting directly upstream of the 32x64 register file. Accepts ALU results through a valid/ready handshake into a small FIFO and merges each result with the old destination value according to the PPP participation field and the WW sub-field width. It arbitrates the single register-file write port between buffered ALU results and NoC load returns, which always take priority. It drives the register file's write enable, address and data directly.

---
 rtl/cardinal_pkg.sv | 43 ++++
 rtl/ppp_mask_gen.sv | 35 +++
 rtl/wb_stage.sv | 162 ++++++++++++++++
 tb/tb_wb_stage.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cardinal_pkg.sv
// -----------------------------------------------------------------------------
// cardinal_pkg
// Shared constants for the write-back path:
//   - DATA_WIDTH / ADDR_WIDTH : register-file geometry (32 x 64)
//   - ppp_e                   : participation field encodings A/U/D/E/O
//   - ww_e                    : sub-field width encodings B/H/W/D
//   - field_is_odd()          : selects odd sub-fields for a given bit index
// Bit numbering is big-endian: bit 0 is the MSB.
// -----------------------------------------------------------------------------
package cardinal_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 5;

  typedef enum logic [2:0] {
    PPP_A = 3'b000,  // all bits
    PPP_U = 3'b001,  // upper half (bits 0-31)
    PPP_D = 3'b010,  // lower half (bits 32-63)
    PPP_E = 3'b011,  // even sub-fields
    PPP_O = 3'b100   // odd sub-fields
  } ppp_e;

  typedef enum logic [1:0] {
    WW_B = 2'b00,    // 8-bit sub-fields
    WW_H = 2'b01,    // 16-bit sub-fields
    WW_W = 2'b10,    // 32-bit sub-fields
    WW_D = 2'b11     // one 64-bit field
  } ww_e;

  // Sub-field k spans bits [k*w, k*w+w-1] in MSB-first numbering, so the
  // parity of k is simply bit log2(w) of the bit index. With a single
  // 64-bit field the index is always 0 (even).
  function automatic logic field_is_odd(input logic [5:0] bit_idx,
                                        input logic [1:0] ww);
    case (ww)
      WW_B:    return bit_idx[3];
      WW_H:    return bit_idx[4];
      WW_W:    return bit_idx[5];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ppp_mask_gen.sv
// -----------------------------------------------------------------------------
// ppp_mask_gen
// Purely combinational merge-mask generator. A mask bit of 1 means the bit
// comes from the new result, 0 means the old destination value is kept.
// Ports:
//   ppp   in  3            participation field (A/U/D/E/O, others reserved)
//   ww    in  2            sub-field width (B/H/W/D)
//   mask  out [0:63]       merge mask, bit 0 = MSB
// Reserved PPP encodings produce an all-zero mask.
// -----------------------------------------------------------------------------
module ppp_mask_gen
  import cardinal_pkg::*;
(
  input  logic [2:0]              ppp,
  input  logic [1:0]              ww,
  output logic [0:DATA_WIDTH-1]   mask
);

  // NOTE: every output of a combinational block gets a default first so no
  // path can leave it unassigned, which would otherwise infer a latch.
  always_comb begin
    mask = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      case (ppp)
        PPP_A:   mask[i] = 1'b1;
        PPP_U:   mask[i] = (i < DATA_WIDTH / 2);
        PPP_D:   mask[i] = (i >= DATA_WIDTH / 2);
        PPP_E:   mask[i] = !field_is_odd(6'(i), ww);
        PPP_O:   mask[i] = field_is_odd(6'(i), ww);
        default: mask[i] = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Write-back stage in front of the 32x64 register file. ALU results are
// merged with the old destination value at enqueue and buffered in a small
// FIFO; NoC load returns bypass the FIFO and always own the write port.
//
// Build option: define WB_PPP_MERGE_EN to enable the PPP/WW partial merge.
// Without it every ALU result is written in full and in_old/in_ppp/in_ww
// are ignored (ports kept for compatibility).
//
// Ports:
//   clk       in   single clock, rising edge
//   reset     in   synchronous active-low reset
//   in_valid  in   ALU result valid
//   in_ready  out  FIFO can accept (count < DEPTH)
//   in_rd     in   ALU destination register
//   in_data   in   ALU new result
//   in_old    in   old destination value read at decode
//   in_ppp    in   participation field
//   in_ww     in   sub-field width
//   ld_valid  in   load return this cycle (never stalled)
//   ld_rd     in   load destination register
//   ld_data   in   load data, always written in full
//   wr_en     out  register-file write enable
//   wr_addr   out  register-file write address
//   wr_data   out  register-file write data
//   pending   out  current FIFO occupancy
// -----------------------------------------------------------------------------
module wb_stage #(
  parameter int DATA_WIDTH = cardinal_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = cardinal_pkg::ADDR_WIDTH,
  parameter int DEPTH      = 2   // power of 2, >= 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_WIDTH-1:0]     in_rd,
  input  logic [0:DATA_WIDTH-1]     in_data,
  input  logic [0:DATA_WIDTH-1]     in_old,
  input  logic [2:0]                in_ppp,
  input  logic [1:0]                in_ww,
  input  logic                      ld_valid,
  input  logic [ADDR_WIDTH-1:0]     ld_rd,
  input  logic [0:DATA_WIDTH-1]     ld_data,
  output logic                      wr_en,
  output logic [ADDR_WIDTH-1:0]     wr_addr,
  output logic [0:DATA_WIDTH-1]     wr_data,
  output logic [$clog2(DEPTH):0]    pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // FIFO storage and control
  logic [0:DATA_WIDTH-1]  r_mem_data [DEPTH];
  logic [ADDR_WIDTH-1:0]  r_mem_rd   [DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;

  // Last value driven onto the write port; held while the port is idle.
  logic [ADDR_WIDTH-1:0]  r_last_addr;
  logic [0:DATA_WIDTH-1]  r_last_data;

  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_sel_valid;
  logic [ADDR_WIDTH-1:0]  w_sel_addr;
  logic [0:DATA_WIDTH-1]  w_sel_data;
  logic [0:DATA_WIDTH-1]  w_merged;

  // ---------------------------------------------------------------------------
  // Merge at enqueue
  // ---------------------------------------------------------------------------
`ifdef WB_PPP_MERGE_EN
  logic [0:DATA_WIDTH-1]  w_mask;

  ppp_mask_gen u_mask_gen (
    .ppp  (in_ppp),
    .ww   (in_ww),
    .mask (w_mask)
  );

  assign w_merged = (in_data & w_mask) | (in_old & ~w_mask);
`else
  logic w_unused;
  assign w_unused = ^{in_old, in_ppp, in_ww};
  assign w_merged = in_data;
`endif

  // ---------------------------------------------------------------------------
  // Handshake and arbitration
  // ---------------------------------------------------------------------------
  assign w_empty  = (r_count == '0);
  // Readiness depends only on the registered count, so a full FIFO refuses
  // input even in a cycle where it also dequeues.
  assign in_ready = (r_count < CNT_W'(DEPTH));
  assign w_push   = in_valid && in_ready;
  // Loads own the port; the FIFO drains only in non-load cycles. Entries
  // targeting r0 still drain, they just never assert wr_en.
  assign w_pop    = !ld_valid && !w_empty;
  assign pending  = r_count;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_addr  = r_last_addr;
    w_sel_data  = r_last_data;
    if (ld_valid) begin
      w_sel_valid = 1'b1;
      w_sel_addr  = ld_rd;
      w_sel_data  = ld_data;
    end else if (!w_empty) begin
      w_sel_valid = 1'b1;
      w_sel_addr  = r_mem_rd[r_rd_ptr];
      w_sel_data  = r_mem_data[r_rd_ptr];
    end
  end

  assign wr_en   = w_sel_valid && (w_sel_addr != '0);
  assign wr_addr = w_sel_addr;
  assign wr_data = w_sel_data;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_last_addr <= '0;
      r_last_data <= '0;
    end else begin
      // DEPTH is a power of 2, so pointer overflow is the modulo wrap.
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_sel_valid) begin
        r_last_addr <= w_sel_addr;
        r_last_data <= w_sel_data;
      end
    end
  end

  // NOTE: the entry storage has no reset; clearing the pointers and count
  // already makes every stored entry unreachable.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_merged;
      r_mem_rd[r_wr_ptr]   <= in_rd;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage
// Self-checking bench for wb_stage: directed scenarios followed by random
// traffic, all compared every cycle against a queue-based reference model.
// Honors WB_PPP_MERGE_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_wb_stage;
  import cardinal_pkg::*;

  localparam int DW    = 64;
  localparam int AW    = 5;
  localparam int DEPTH = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [AW-1:0]     in_rd;
  logic [0:DW-1]     in_data;
  logic [0:DW-1]     in_old;
  logic [2:0]        in_ppp;
  logic [1:0]        in_ww;
  logic              ld_valid;
  logic [AW-1:0]     ld_rd;
  logic [0:DW-1]     ld_data;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [0:DW-1]     wr_data;
  logic [1:0]        pending;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_rd    (in_rd),
    .in_data  (in_data),
    .in_old   (in_old),
    .in_ppp   (in_ppp),
    .in_ww    (in_ww),
    .ld_valid (ld_valid),
    .ld_rd    (ld_rd),
    .ld_data  (ld_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .pending  (pending)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [AW-1:0] rd;
    logic [63:0]   val;
  } ent_t;

  ent_t q[$];

  // Last observed outputs (sampled mid-cycle on the falling edge)
  logic          obs_en;
  logic          obs_ready;
  logic [AW-1:0] obs_addr;
  logic [63:0]   obs_data;
  logic [1:0]    obs_pend;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference merge: built field by field from the rules, MSB field first.
  function automatic logic [63:0] ref_merge(input logic [63:0] d,
                                            input logic [63:0] old,
                                            input logic [2:0]  ppp,
                                            input logic [1:0]  ww);
    logic [63:0] m;
`ifdef WB_PPP_MERGE_EN
    int          w;
    logic [63:0] ones;
    m = '0;
    case (ppp)
      3'd0: m = '1;
      3'd1: m = 64'hFFFF_FFFF_0000_0000;
      3'd2: m = 64'h0000_0000_FFFF_FFFF;
      3'd3, 3'd4: begin
        w    = 8 << ww;
        ones = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        for (int k = 0; k < 64 / w; k++)
          if (((k % 2) == 1) == (ppp == 3'd4))
            m |= ones << (64 - (k + 1) * w);
      end
      default: m = '0;
    endcase
`else
    m = '1;
`endif
    return (d & m) | (old & ~m);
  endfunction

  // One clock cycle with the inputs currently driven: sample and compare
  // mid-cycle, then advance the model at the rising edge.
  task automatic cycle();
    int            sz;
    logic          exp_sel;
    logic [AW-1:0] exp_addr;
    logic [63:0]   exp_data;
    ent_t          dummy;
    @(negedge clk);
    obs_en    = wr_en;
    obs_ready = in_ready;
    obs_addr  = wr_addr;
    obs_data  = wr_data;
    obs_pend  = pending;
    sz        = q.size();
    exp_sel   = ld_valid || (sz > 0);
    exp_addr  = '0;
    exp_data  = '0;
    if (ld_valid) begin
      exp_addr = ld_rd;
      exp_data = ld_data;
    end else if (sz > 0) begin
      exp_addr = q[0].rd;
      exp_data = q[0].val;
    end
    check("in_ready", 64'(obs_ready), 64'(sz < DEPTH));
    check("pending", 64'(obs_pend), 64'(sz));
    check("wr_en", 64'(obs_en), 64'(exp_sel && (exp_addr != '0)));
    if (exp_sel) begin
      check("wr_addr", 64'(obs_addr), 64'(exp_addr));
      check("wr_data", obs_data, exp_data);
    end
    @(posedge clk);
    if (!reset) begin
      q.delete();
    end else begin
      if (!ld_valid && sz > 0) dummy = q.pop_front();
      if (in_valid && sz < DEPTH)
        q.push_back('{in_rd, ref_merge(in_data, in_old, in_ppp, in_ww)});
    end
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    ld_valid = 1'b0;
  endtask

  task automatic set_alu(input logic [AW-1:0] rd, input logic [63:0] d,
                         input logic [63:0] old, input logic [2:0] ppp,
                         input logic [1:0] ww);
    in_valid = 1'b1;
    in_rd    = rd;
    in_data  = d;
    in_old   = old;
    in_ppp   = ppp;
    in_ww    = ww;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    logic [63:0] merge_exp [3];
    logic [2:0]  merge_ppp [3];
    logic [1:0]  merge_ww  [3];
    int          n_acc;
    int          third_cyc;

    reset    = 1'b0;
    in_valid = 1'b0;
    in_rd    = '0;
    in_data  = '0;
    in_old   = '0;
    in_ppp   = '0;
    in_ww    = '0;
    ld_valid = 1'b0;
    ld_rd    = '0;
    ld_data  = '0;

    // Reset
    @(posedge clk); #1;
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    check("rst_pending", 64'(obs_pend), 64'd0);
    check("rst_ready", 64'(obs_ready), 64'd1);
    check("rst_wr_en", 64'(obs_en), 64'd0);

    // Single ALU result, PPP a
    set_alu(5'd5, 64'h1111_1111_1111_1111, 64'h0, PPP_A, WW_D);
    cycle();
    idle();
    cycle();
    check("t1_wr_en", 64'(obs_en), 64'd1);
    check("t1_wr_addr", 64'(obs_addr), 64'd5);
    check("t1_wr_data", obs_data, 64'h1111_1111_1111_1111);
    cycle();
    check("t1_pending", 64'(obs_pend), 64'd0);

    // Merge patterns
    merge_ppp[0] = PPP_U; merge_ww[0] = WW_B;
    merge_ppp[1] = PPP_E; merge_ww[1] = WW_B;
    merge_ppp[2] = PPP_O; merge_ww[2] = WW_H;
`ifdef WB_PPP_MERGE_EN
    merge_exp[0] = 64'h5555_5555_AAAA_AAAA;
    merge_exp[1] = 64'h55AA_55AA_55AA_55AA;
    merge_exp[2] = 64'hAAAA_5555_AAAA_5555;
`else
    merge_exp[0] = 64'h5555_5555_5555_5555;
    merge_exp[1] = 64'h5555_5555_5555_5555;
    merge_exp[2] = 64'h5555_5555_5555_5555;
`endif
    for (int i = 0; i < 3; i++) begin
      set_alu(5'd3, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA,
              merge_ppp[i], merge_ww[i]);
      cycle();
      idle();
      cycle();
      check($sformatf("merge_%0d", i), obs_data, merge_exp[i]);
    end

    // Loads for 4 cycles while pushing 3 ALU results
    n_acc     = 0;
    third_cyc = 0;
    for (int c = 1; c <= 12; c++) begin
      ld_valid = (c <= 4);
      ld_rd    = AW'(10 + c);
      ld_data  = {$urandom, $urandom};
      if (n_acc < 3) set_alu(AW'(20 + n_acc), {$urandom, $urandom}, 64'h0, PPP_A, WW_D);
      else in_valid = 1'b0;
      cycle();
      if (in_valid && obs_ready) begin
        n_acc++;
        if (n_acc == 3) third_cyc = c;
      end
      if (c == 3) check("t3_ready_low", 64'(obs_ready), 64'd0);
      if (c == 4) check("t3_load_addr", 64'(obs_addr), 64'd14);
      if (c == 5) check("t3_first_drain", 64'(obs_addr), 64'd20);
    end
    idle();
    check("t3_third_accept_cycle", 64'(third_cyc), 64'd6);

    // rd = 0 then rd = 7
    set_alu(5'd0, 64'hDEAD_BEEF_0000_0001, 64'h0, PPP_A, WW_D);
    cycle();
    set_alu(5'd7, 64'h0123_4567_89AB_CDEF, 64'h0, PPP_A, WW_D);
    cycle();
    check("t4_r0_no_write", 64'(obs_en), 64'd0);
    idle();
    cycle();
    check("t4_pending", 64'(obs_pend), 64'd1);
    check("t4_rd7_en", 64'(obs_en), 64'd1);
    check("t4_rd7_addr", 64'(obs_addr), 64'd7);
    cycle();

    // Fill the FIFO behind a load, then reset for one edge
    ld_valid = 1'b1;
    ld_rd    = 5'd9;
    ld_data  = 64'h0F0F_0F0F_0F0F_0F0F;
    set_alu(5'd12, 64'hCAFE, 64'h0, PPP_A, WW_D);
    cycle();
    set_alu(5'd13, 64'hBEEF, 64'h0, PPP_A, WW_D);
    cycle();
    idle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    check("t5_pending", 64'(obs_pend), 64'd0);
    check("t5_ready", 64'(obs_ready), 64'd1);
    check("t5_no_stale", 64'(obs_en), 64'd0);
    cycle();
    check("t5_no_stale2", 64'(obs_en), 64'd0);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      reset    = ($urandom_range(0, 49) != 0);
      ld_valid = ($urandom_range(0, 2) == 0);
      ld_rd    = AW'($urandom_range(0, 31));
      ld_data  = {$urandom, $urandom};
      in_valid = $urandom_range(0, 1) == 1;
      in_rd    = AW'($urandom_range(0, 31));
      in_data  = {$urandom, $urandom};
      in_old   = {$urandom, $urandom};
      in_ppp   = 3'($urandom_range(0, 7));
      in_ww    = 2'($urandom_range(0, 3));
      cycle();
    end
    reset = 1'b1;
    idle();
    cycle();
    cycle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
